// File: rtl/ongoru_guncelleme_denetleyici_if.sv
// Port bundle for the branch-predictor update controller: two resolution
// requesters in, one predictor update stream and status out.
interface ongoru_guncelleme_denetleyici_if;
  // Requester handshake: a record is presented with *_gecerli_i and held
  // stable until the cycle *_hazir_o is 1; transfer happens on that edge.
  // The update stream has no ready: guncelle_gecerli_o means "popped now".
  logic        a_gecerli_i;
  logic [31:0] a_ps_i;
  logic        a_atladi_i;
  logic        a_tahmin_i;
  logic        a_hazir_o;
  logic        b_gecerli_i;
  logic [31:0] b_ps_i;
  logic        b_atladi_i;
  logic        b_tahmin_i;
  logic        b_hazir_o;
  logic        durdur_i;
  logic        guncelle_gecerli_o;
  logic        guncelle_atladi_o;
  logic [31:0] guncelle_ps_o;
  logic        yanlis_o;
  logic [15:0] yanlis_sayac_o;
  logic        dolu_o;
  logic        bos_o;

  modport master (
    output a_gecerli_i, a_ps_i, a_atladi_i, a_tahmin_i,
    output b_gecerli_i, b_ps_i, b_atladi_i, b_tahmin_i,
    output durdur_i,
    input  a_hazir_o, b_hazir_o,
    input  guncelle_gecerli_o, guncelle_atladi_o, guncelle_ps_o,
    input  yanlis_o, yanlis_sayac_o, dolu_o, bos_o
  );

  modport slave (
    input  a_gecerli_i, a_ps_i, a_atladi_i, a_tahmin_i,
    input  b_gecerli_i, b_ps_i, b_atladi_i, b_tahmin_i,
    input  durdur_i,
    output a_hazir_o, b_hazir_o,
    output guncelle_gecerli_o, guncelle_atladi_o, guncelle_ps_o,
    output yanlis_o, yanlis_sayac_o, dolu_o, bos_o
  );
endinterface

// File: rtl/ongoru_guncelleme_denetleyici.sv
// Branch-predictor update controller: round-robin arbitration of two
// resolution requesters into a circular update queue, plus mispredict tracking.
module ongoru_guncelleme_denetleyici #(
  parameter int DERINLIK = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  ongoru_guncelleme_denetleyici_if.slave bag,
  output logic                          durum_o
);

  localparam int            AW        = $clog2(DERINLIK);
  localparam logic [AW:0]   DOLU_SAYI = (AW+1)'(DERINLIK);

  typedef enum logic {
    ONCELIK_A = 1'b0,
    ONCELIK_B = 1'b1
  } durum_t;

  durum_t          durum_q, durum_d;
  logic [AW-1:0]   yaz_ptr_q, oku_ptr_q;
  logic [AW:0]     sayac_q;
  logic [32:0]     bellek [DERINLIK];
  logic            dolu, bos;
  logic            izin_a, izin_b;
  logic            it, cek;
  logic [32:0]     it_veri;
  logic            it_yanlis;
  logic [32:0]     bas_veri;
  logic            yanlis_q;
  logic [15:0]     yanlis_sayac_q;

  assign dolu = (sayac_q == DOLU_SAYI);
  assign bos  = (sayac_q == '0);

  // Arbiter state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q <= ONCELIK_A;
    end else begin
      durum_q <= durum_d;
    end
  end

  // Priority passes to whoever was not served this cycle
  always_comb begin
    durum_d = durum_q;
    if (izin_a) begin
      durum_d = ONCELIK_B;
    end else if (izin_b) begin
      durum_d = ONCELIK_A;
    end
  end

  // Grant outputs; reset gating keeps both grants low while rst_i is asserted
  always_comb begin
    izin_a = 1'b0;
    izin_b = 1'b0;
    if (rst_i && !dolu) begin
      if (bag.a_gecerli_i && (!bag.b_gecerli_i || durum_q == ONCELIK_A)) begin
        izin_a = 1'b1;
      end else if (bag.b_gecerli_i) begin
        izin_b = 1'b1;
      end
    end
  end

  assign it      = izin_a | izin_b;
  assign cek     = !bos && !bag.durdur_i;
  assign it_veri = izin_a ? {bag.a_ps_i, bag.a_atladi_i} : {bag.b_ps_i, bag.b_atladi_i};

  always_comb begin
    it_yanlis = 1'b0;
    if (izin_a) begin
      it_yanlis = bag.a_atladi_i ^ bag.a_tahmin_i;
    end else if (izin_b) begin
      it_yanlis = bag.b_atladi_i ^ bag.b_tahmin_i;
    end
  end

  // Pointers wrap naturally because DERINLIK is a power of two
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      sayac_q   <= '0;
    end else begin
      if (it) begin
        yaz_ptr_q <= yaz_ptr_q + 1'b1;
      end
      if (cek) begin
        oku_ptr_q <= oku_ptr_q + 1'b1;
      end
      case ({it, cek})
        2'b10:   sayac_q <= sayac_q + 1'b1;
        2'b01:   sayac_q <= sayac_q - 1'b1;
        default: sayac_q <= sayac_q;
      endcase
    end
  end

  // Storage is not reset; bos hides stale entries
  always_ff @(posedge clk_i) begin
    if (it) begin
      bellek[yaz_ptr_q] <= it_veri;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      yanlis_q       <= 1'b0;
      yanlis_sayac_q <= '0;
    end else begin
      yanlis_q <= it_yanlis;
      if (it_yanlis && yanlis_sayac_q != 16'hFFFF) begin
        yanlis_sayac_q <= yanlis_sayac_q + 16'd1;
      end
    end
  end

  assign bas_veri = bos ? '0 : bellek[oku_ptr_q];

  assign bag.a_hazir_o          = izin_a;
  assign bag.b_hazir_o          = izin_b;
  assign bag.guncelle_gecerli_o = cek;
  assign bag.guncelle_ps_o      = bas_veri[32:1];
  assign bag.guncelle_atladi_o  = bas_veri[0];
  assign bag.yanlis_o           = yanlis_q;
  assign bag.yanlis_sayac_o     = yanlis_sayac_q;
  assign bag.dolu_o             = dolu;
  assign bag.bos_o              = bos;
  assign durum_o                = logic'(durum_q);

endmodule

// File: doc/ongoru_guncelleme_denetleyici.md
ONGORU_GUNCELLEME_DENETLEYICI -- requirements
Module: ongoru_guncelleme_denetleyici

Interface
REQ-001 Parameter: DERINLIK, 4, update-queue depth in entries (power of two, 2..16).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 a_gecerli_i  input  1  requester A (branch unit) resolution record valid.
REQ-005 a_ps_i  input  32  requester A branch program counter.
REQ-006 a_atladi_i  input  1  requester A actual outcome (1 = taken).
REQ-007 a_tahmin_i  input  1  requester A predicted outcome (1 = taken).
REQ-008 a_hazir_o  output  1  requester A record accepted this cycle.
REQ-009 b_gecerli_i, b_ps_i, b_atladi_i, b_tahmin_i, b_hazir_o  same widths/directions/meanings as A, requester B (jump unit).
REQ-010 durdur_i  input  1  predictor busy; suppress queue drain.
REQ-011 guncelle_gecerli_o  output  1  predictor update strobe.
REQ-012 guncelle_atladi_o  output  1  outcome of head entry.
REQ-013 guncelle_ps_o  output  32  program counter of head entry.
REQ-014 yanlis_o  output  1  one-cycle misprediction pulse.
REQ-015 yanlis_sayac_o  output  16  accepted-misprediction count.
REQ-016 dolu_o / bos_o  output  1 each  queue full / queue empty.

Function
REQ-017 Queue: circular FIFO, DERINLIK entries of {ps[31:0], atladi}; read/write pointers wrap modulo DERINLIK; occupancy counter 0..DERINLIK.
REQ-018 dolu_o = (count == DERINLIK); bos_o = (count == 0); both from registered count only.
REQ-019 Arbiter states ONCELIK_A, ONCELIK_B (priority holder); reset state ONCELIK_A.
REQ-020 Grant only when !dolu_o; at most one grant per cycle; a_hazir_o/b_hazir_o are the combinational grant and are never both 1.
REQ-021 Both valid: grant priority holder; next state = other requester.
REQ-022 One valid: grant it regardless of state; next state = other requester.
REQ-023 None valid or dolu_o: no grant; state unchanged.
REQ-024 Granted record written at write pointer on the clock edge of acceptance; no bypass -- earliest appearance on guncelle_*_o is the following cycle.
REQ-025 guncelle_gecerli_o = !bos_o && !durdur_i (combinational); guncelle_ps_o/atladi_o = head entry; pop on every cycle guncelle_gecerli_o = 1.
REQ-026 When bos_o, guncelle_ps_o = 0 and guncelle_atladi_o = 0.
REQ-027 Simultaneous push and pop: count unchanged, both pointers advance; push while full is impossible (REQ-020), pop while empty is impossible (REQ-025).
REQ-028 Misprediction = granted record with atladi != tahmin; yanlis_o registered, high exactly the cycle after acceptance.
REQ-029 Ungranted requests are never counted; requester holds record until its hazir_o = 1.
REQ-030 yanlis_sayac_o increments by 1 per misprediction, saturates at 16'hFFFF.
REQ-031 durdur_i does not block acceptance; queue fills, then dolu_o back-pressures both requesters.

Reset
REQ-032 rst_i = 0 immediately (no clock) clears pointers, count, arbiter to ONCELIK_A, yanlis_o = 0, yanlis_sayac_o = 0; queue contents undefined but never presented (bos_o = 1).
REQ-033 During reset: a_hazir_o = b_hazir_o = 0, guncelle_gecerli_o = 0, dolu_o = 0, bos_o = 1.
REQ-034 Reset mid-operation discards all queued records and pending yanlis_o pulse; first edge after release behaves as from power-up.
REQ-035 Reset release is synchronised externally; block is not required to tolerate release in the same cycle as a request.

Verification
REQ-036 A only, ps=0x100, atladi=1, tahmin=1 -> a_hazir_o=1 that cycle; next cycle guncelle_gecerli_o=1, ps=0x100, atladi=1; yanlis_o=0.
REQ-037 A and B valid every cycle from reset, durdur_i=0 -> grants alternate A,B,A,B; output order matches grant order.
REQ-038 durdur_i=1, A valid 5 cycles (DERINLIK=4) -> 4 accepted, dolu_o=1, 5th held with a_hazir_o=0; release durdur_i -> 4 pops in order, 5th accepted on first cycle count<4.
REQ-039 B ps=0x200, atladi=0, tahmin=1 -> yanlis_o pulses 1 cycle after acceptance, yanlis_sayac_o 0->1; preload counter to 0xFFFF via 65535 mispredicts -> stays 0xFFFF.
REQ-040 Queue holding 3 entries, drop rst_i asynchronously between edges -> bos_o=1, guncelle_gecerli_o=0 immediately; after release, next grant goes to A when A and B both valid.
